arb_req_agent: RTL and testbench

Requester-side agent for the fixed-priority req/gnt arbiters in the arbiter library; one instance sits on each client port of a shared bus.
- Accepts a burst command and its write beats from the client.
- Raises req, drives beats onto the shared bus only in cycles where gnt is high, and drops req after the last beat.
- Tolerates losing gnt mid-burst to a higher-priority client and reports prolonged starvation.

---
 rtl/arb_req_agent_if.sv | 36 +++
 rtl/arb_req_agent.sv | 142 ++++++++++++++
 tb/tb_arb_req_agent.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/arb_req_agent_if.sv
// Client/bus handshake bundle for the requester-side arbiter agent.
// master is the agent view, slave is the client/arbiter view.
interface arb_req_agent_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  req;
  logic                  gnt;
  logic                  bus_valid;
  logic [DATA_WIDTH-1:0] bus_data;
  logic                  bus_last;
  logic                  busy;
  logic                  starve;

  modport master (
    input  cmd_valid, cmd_len,
    input  wr_valid, wr_data, gnt,
    output cmd_ready, wr_ready, req,
    output bus_valid, bus_data, bus_last,
    output busy, starve
  );

  modport slave (
    output cmd_valid, cmd_len,
    output wr_valid, wr_data, gnt,
    input  cmd_ready, wr_ready, req,
    input  bus_valid, bus_data, bus_last,
    input  busy, starve
  );
endinterface

// File: rtl/arb_req_agent.sv
// Requester agent: takes a burst command plus write beats and
// drives them onto a shared bus only while the arbiter grants.
module arb_req_agent #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int MAX_WAIT   = 64
) (
  input logic            clk,
  input logic            rst,
  arb_req_agent_if.master io
);

  localparam int CW = LEN_WIDTH + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [WW-1:0] W_ONE  = WW'(1);
  localparam logic [WW-1:0] W_MAX  = WW'(MAX_WAIT);
  localparam logic [WW-1:0] W_LAST = WW'(MAX_WAIT - 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t                state;
  logic                  req_q;
  logic                  busy_q;
  logic                  cmd_ready_q;
  logic                  starve_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [CW-1:0]         in_cnt;
  logic [CW-1:0]         out_cnt;
  logic [WW-1:0]         wait_cnt;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  hold_valid;

  logic [CW-1:0] len_ext;
  logic          active;
  logic          owed;
  logic          fire;
  logic          accept;
  logic          last_fire;
  logic          cmd_fire;
  logic          wr_ready;

  assign len_ext   = {1'b0, len_q};
  assign active    = (state == ACTIVE);
  assign owed      = (in_cnt <= len_ext);
  assign fire      = hold_valid & io.gnt;
  assign wr_ready  = active & owed & (~hold_valid | fire);
  assign accept    = io.wr_valid & wr_ready;
  assign last_fire = fire & (out_cnt == len_ext);
  assign cmd_fire  = cmd_ready_q & io.cmd_valid;

  assign io.cmd_ready = cmd_ready_q;
  assign io.wr_ready  = wr_ready;
  assign io.req       = req_q;
  assign io.busy      = busy_q;
  assign io.starve    = starve_q;
  assign io.bus_valid = hold_valid;
  assign io.bus_data  = hold_q;
  assign io.bus_last  = hold_valid & (out_cnt == len_ext);

  // Burst FSM: command capture, request, and return to idle on last beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      len_q       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (io.cmd_valid) begin
            state       <= ACTIVE;
            len_q       <= io.cmd_len;
            req_q       <= 1'b1;
            busy_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
          end
        end
        ACTIVE: begin
          if (last_fire) begin
            state       <= IDLE;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  // Single-entry hold register; accept and fire together keep 1 beat/cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt     <= '0;
      out_cnt    <= '0;
      hold_q     <= '0;
      hold_valid <= 1'b0;
    end else if (cmd_fire) begin
      in_cnt     <= '0;
      out_cnt    <= '0;
      hold_valid <= 1'b0;
    end else begin
      if (accept) begin
        hold_q <= io.wr_data;
        in_cnt <= in_cnt + C_ONE;
      end
      if (fire) begin
        out_cnt <= out_cnt + C_ONE;
      end
      if (accept) begin
        hold_valid <= 1'b1;
      end else if (fire) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // Starvation watch: count ungranted request cycles, flag is sticky
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      starve_q <= 1'b0;
    end else if (!active || last_fire) begin
      wait_cnt <= '0;
      starve_q <= 1'b0;
    end else if (io.gnt) begin
      wait_cnt <= '0;
    end else if (req_q) begin
      if (wait_cnt != W_MAX) begin
        wait_cnt <= wait_cnt + W_ONE;
      end
      if (wait_cnt == W_LAST) begin
        starve_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arb_req_agent.sv
// Scoreboard bench for arb_req_agent: beats are queued as the
// client hands them over and checked as they fire on the bus.
module tb_arb_req_agent;

  localparam int DW = 32;
  localparam int LW = 4;

  logic clk;
  logic rst;
  bit   rnd_gnt;

  int n_tests;
  int n_fail;
  int nfires;
  int run_len;
  int cyc;
  int last_cyc;
  bit after_last;

  logic [DW:0] sb[$];
  logic [DW:0] exp_beat;

  arb_req_agent_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) ifc ();

  arb_req_agent #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW),
    .MAX_WAIT  (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // random grant source used by the max-length burst
  always @(posedge clk) begin
    #1;
    if (rnd_gnt) ifc.gnt = 1'($urandom_range(0, 1));
  end

  // bus monitor: pop and compare on every fire
  always @(negedge clk) begin
    cyc++;
    if (after_last) begin
      after_last = 1'b0;
      chk("req_drop", ifc.req, 1'b0);
      chk("cmd_ready_back", ifc.cmd_ready, 1'b1);
    end
    if (!rst && ifc.bus_valid && ifc.gnt) begin
      nfires++;
      run_len = (cyc == last_cyc + 1) ? run_len + 1 : 1;
      last_cyc = cyc;
      if (sb.size() == 0) begin
        chk("extra_beat", ifc.bus_data, 64'hdead);
      end else begin
        exp_beat = sb.pop_front();
        chk("bus_data", ifc.bus_data, exp_beat[DW-1:0]);
        chk("bus_last", ifc.bus_last, exp_beat[DW]);
      end
      if (ifc.bus_last) after_last = 1'b1;
    end
  end

  task automatic send_cmd(input int len);
    int t;
    t = 0;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_len   = LW'(len);
    @(negedge clk);
    while (!ifc.cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("cmd_timeout", 0, 1);
    @(posedge clk);
    #1;
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic send_beats(input int len, input int nb,
                            input logic [DW-1:0] base, input bit gaps);
    int t;
    int g;
    for (int i = 1; i <= nb; i++) begin
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      ifc.wr_valid = 1'b0;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
      ifc.wr_valid = 1'b1;
      ifc.wr_data  = base + DW'(i);
      t = 0;
      @(negedge clk);
      while (!ifc.wr_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) chk("wr_timeout", 0, 1);
      else sb.push_back({(i == len + 1), base + DW'(i)});
      @(posedge clk);
      #1;
    end
    ifc.wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    @(negedge clk);
    while ((ifc.busy || !ifc.cmd_ready) && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (t >= budget) chk("idle_timeout", 0, 1);
    chk("sb_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  int f0;

  initial begin
    n_tests = 0;
    n_fail = 0;
    nfires = 0;
    run_len = 0;
    cyc = 0;
    last_cyc = -10;
    after_last = 1'b0;
    rnd_gnt = 1'b0;
    rst = 1'b1;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_len = '0;
    ifc.wr_valid = 1'b0;
    ifc.wr_data = '0;
    ifc.gnt = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", ifc.cmd_ready, 1'b1);
    chk("rst_req", ifc.req, 1'b0);
    chk("rst_busy", ifc.busy, 1'b0);
    chk("rst_bus_valid", ifc.bus_valid, 1'b0);
    chk("rst_wr_ready", ifc.wr_ready, 1'b0);
    chk("rst_starve", ifc.starve, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single beat
    f0 = nfires;
    send_cmd(0);
    chk("single_req_up", ifc.req, 1'b1);
    chk("single_cmd_ready", ifc.cmd_ready, 1'b0);
    chk("single_busy", ifc.busy, 1'b1);
    send_beats(0, 1, 32'hA5A5_0000, 1'b0);
    wait_idle(50);
    chk("single_fires", nfires - f0, 1);

    // full-rate burst
    f0 = nfires;
    send_cmd(3);
    send_beats(3, 4, 32'h0, 1'b0);
    chk("full_wr_ready_off", ifc.wr_ready, 1'b0);
    wait_idle(50);
    chk("full_fires", nfires - f0, 4);
    chk("full_rate_run", run_len, 4);

    // grant stolen after beat 2
    f0 = nfires;
    send_cmd(3);
    fork
      send_beats(3, 4, 32'h300, 1'b0);
      begin
        int t;
        t = 0;
        while (nfires - f0 < 2 && t < 50) begin
          @(negedge clk);
          #1;
          t++;
        end
        if (t >= 50) chk("steal_timeout", 0, 1);
        @(posedge clk);
        #1;
        ifc.gnt = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("held_valid", ifc.bus_valid, 1'b1);
          chk("held_data", ifc.bus_data, 32'h303);
          chk("held_last", ifc.bus_last, 1'b0);
        end
        @(posedge clk);
        #1;
        ifc.gnt = 1'b1;
      end
    join
    wait_idle(50);
    chk("steal_fires", nfires - f0, 4);

    // starvation with MAX_WAIT=8
    f0 = nfires;
    ifc.gnt = 1'b0;
    send_cmd(1);
    fork
      send_beats(1, 2, 32'h500, 1'b0);
      begin
        repeat (8) @(negedge clk);
        chk("starve_early", ifc.starve, 1'b0);
        @(negedge clk);
        chk("starve_set", ifc.starve, 1'b1);
        @(posedge clk);
        #1;
        ifc.gnt = 1'b1;
        @(negedge clk);
        chk("starve_sticky", ifc.starve, 1'b1);
      end
    join
    wait_idle(50);
    chk("starve_clear", ifc.starve, 1'b0);
    chk("starve_fires", nfires - f0, 2);

    // max-length burst with random gaps
    f0 = nfires;
    rnd_gnt = 1'b1;
    send_cmd(15);
    send_beats(15, 16, 32'h1000, 1'b1);
    wait_idle(1000);
    chk("max_fires", nfires - f0, 16);
    @(posedge clk);
    #2;
    rnd_gnt = 1'b0;
    ifc.gnt = 1'b1;

    // reset mid-burst
    f0 = nfires;
    send_cmd(3);
    send_beats(3, 3, 32'h700, 1'b0);
    chk("rst_mid_fires", nfires - f0, 2);
    chk("rst_mid_pre_valid", ifc.bus_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_req", ifc.req, 1'b0);
    chk("rst_mid_bus_valid", ifc.bus_valid, 1'b0);
    chk("rst_mid_busy", ifc.busy, 1'b0);
    chk("rst_mid_cmd_ready", ifc.cmd_ready, 1'b1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    f0 = nfires;
    send_cmd(0);
    send_beats(0, 1, 32'h800, 1'b0);
    wait_idle(50);
    chk("post_rst_fires", nfires - f0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
